// File: rtl/cordic_sign_unit.sv
// cordic_sign_unit: registered per-channel sign, zero, saturated magnitude and sign-flip detection
// behind a single-register valid/ready stage.
module cordic_sign_unit #(
  parameter int NUM_WIDTH = 16,
  parameter int NUM_CH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_CH*NUM_WIDTH-1:0] in_data,
  input  logic                        mode,
  input  logic                        clear_hist,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_CH-1:0]           sign_ans,
  output logic [NUM_CH-1:0]           zero,
  output logic [NUM_CH*NUM_WIDTH-1:0] mag,
  output logic [NUM_CH-1:0]           sat,
  output logic [NUM_CH-1:0]           flip
);
  localparam int W = NUM_WIDTH;
  localparam int T = NUM_CH * NUM_WIDTH;
  logic              out_valid_q, out_valid_d, accept;
  logic [NUM_CH-1:0] sign_q, sign_d, zero_q, zero_d, sat_q, sat_d, flip_q, flip_d;
  logic [NUM_CH-1:0] hv_q, hv_d, hs_q, hs_d, hv_live;
  logic [NUM_CH-1:0] c_sign, c_zero, c_sat, c_flip;
  logic [T-1:0]      mag_q, mag_d, c_mag;
  assign in_ready = rst | ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready & ~rst;
  assign hv_live  = clear_hist ? '0 : hv_q;
  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      logic [W-1:0] w, tc_mag;
      logic         is_min;
      assign w      = in_data[g*W +: W];
      assign is_min = (w == {1'b1, {(W-1){1'b0}}});
      assign tc_mag = is_min ? {1'b0, {(W-1){1'b1}}} : (w[W-1] ? (~w + 1'b1) : w);
      assign c_mag[g*W +: W] = mode ? {1'b0, w[W-2:0]} : tc_mag;
      // Two's-complement zero implies MSB=0, so masking by zero also normalises -0.
      assign c_zero[g] = ~|c_mag[g*W +: W];
      assign c_sign[g] = w[W-1] & ~c_zero[g];
      assign c_sat[g]  = ~mode & is_min;
      assign c_flip[g] = ~c_zero[g] & hv_live[g] & (hs_q[g] != c_sign[g]);
    end
  endgenerate
  always_comb begin
    out_valid_d = accept | (out_valid_q & ~out_ready);
    sign_d      = accept ? c_sign : sign_q;
    zero_d      = accept ? c_zero : zero_q;
    mag_d       = accept ? c_mag : mag_q;
    sat_d       = accept ? c_sat : sat_q;
    flip_d      = accept ? c_flip : flip_q;
    hv_d        = accept ? (hv_live | ~c_zero) : hv_live;
    hs_d        = accept ? ((c_sign & ~c_zero) | (hs_q & c_zero)) : hs_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sign_q      <= '0;
      zero_q      <= '0;
      mag_q       <= '0;
      sat_q       <= '0;
      flip_q      <= '0;
      hv_q        <= '0;
      hs_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      sign_q      <= sign_d;
      zero_q      <= zero_d;
      mag_q       <= mag_d;
      sat_q       <= sat_d;
      flip_q      <= flip_d;
      hv_q        <= hv_d;
      hs_q        <= hs_d;
    end
  end
  assign out_valid = out_valid_q;
  assign sign_ans  = sign_q;
  assign zero      = zero_q;
  assign mag       = mag_q;
  assign sat       = sat_q;
  assign flip      = flip_q;
endmodule

// File: tb/tb_cordic_sign_unit.sv
// tb_cordic_sign_unit: directed vectors with hand-computed expectations for cordic_sign_unit
// (NUM_WIDTH=16, NUM_CH=2).
module tb_cordic_sign_unit;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, mode, clear_hist, out_valid, out_ready;
  logic [31:0] in_data, mag;
  logic [1:0]  sign_ans, zero, sat, flip;
  int          checks = 0;
  int          failures = 0;
  cordic_sign_unit #(.NUM_WIDTH(16), .NUM_CH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mode(mode), .clear_hist(clear_hist), .out_valid(out_valid), .out_ready(out_ready),
    .sign_ans(sign_ans), .zero(zero), .mag(mag), .sat(sat), .flip(flip)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic ov, input logic [1:0] s, input logic [1:0] z,
                         input logic [31:0] m, input logic [1:0] st, input logic [1:0] f);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".sign"}, 32'(sign_ans), 32'(s));
    chk({tag, ".zero"}, 32'(zero), 32'(z));
    chk({tag, ".mag"}, mag, m);
    chk({tag, ".sat"}, 32'(sat), 32'(st));
    chk({tag, ".flip"}, 32'(flip), 32'(f));
  endtask
  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 1'b0; clear_hist = 1'b0; in_data = '0;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk_out("reset", 1'b0, 2'b00, 2'b00, 32'h0, 2'b00, 2'b00);
    rst = 1'b0;
    // ch0 sequence in two's complement, ch1 a steady positive value
    in_valid = 1'b1; in_data = {16'h0001, 16'h0F50};
    tick();
    chk_out("b1", 1'b1, 2'b00, 2'b00, {16'h0001, 16'h0F50}, 2'b00, 2'b00);
    in_data = {16'h0001, 16'hFF50};
    tick();
    chk_out("b2", 1'b1, 2'b01, 2'b00, {16'h0001, 16'h00B0}, 2'b00, 2'b01);
    in_data = {16'h0001, 16'hFFFF};
    tick();
    chk_out("b3", 1'b1, 2'b01, 2'b00, {16'h0001, 16'h0001}, 2'b00, 2'b00);
    // most-negative saturates; ch0 zero leaves its negative history intact
    in_data = {16'h8000, 16'h0000};
    tick();
    chk_out("min_sat", 1'b1, 2'b10, 2'b01, {16'h7FFF, 16'h0000}, 2'b10, 2'b10);
    in_data = {16'h0002, 16'hFFFE};
    tick();
    chk_out("b5", 1'b1, 2'b00 | 2'b01, 2'b00, {16'h0002, 16'h0002}, 2'b00, 2'b10);
    // sign-magnitude: ch1 is negative zero
    mode = 1'b1; in_data = {16'h8000, 16'h8005};
    tick();
    chk_out("sm_negzero", 1'b1, 2'b01, 2'b10, {16'h0000, 16'h0005}, 2'b00, 2'b00);
    in_data = {16'h0003, 16'h0005};
    tick();
    chk_out("sm_after_zero", 1'b1, 2'b00, 2'b00, {16'h0003, 16'h0005}, 2'b00, 2'b01);
    // backpressure: first beat A, then B held while out_ready=0
    mode = 1'b0; in_data = {16'h0200, 16'h0100};
    tick();
    chk_out("bp_a", 1'b1, 2'b00, 2'b00, {16'h0200, 16'h0100}, 2'b00, 2'b00);
    out_ready = 1'b0; in_data = {16'h0300, 16'hFF00};
    #1;
    chk("bp_in_ready0", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
      chk_out("bp_hold", 1'b1, 2'b00, 2'b00, {16'h0200, 16'h0100}, 2'b00, 2'b00);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk_out("bp_b", 1'b1, 2'b01, 2'b00, {16'h0300, 16'h0100}, 2'b00, 2'b01);
    in_valid = 1'b0;
    tick();
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    // clear_hist alongside the accept hides ch0's negative history
    in_valid = 1'b1; clear_hist = 1'b1; in_data = {16'h0300, 16'h0010};
    tick();
    chk_out("clr", 1'b1, 2'b00, 2'b00, {16'h0300, 16'h0010}, 2'b00, 2'b00);
    clear_hist = 1'b0; in_data = {16'h0300, 16'hFFF0};
    tick();
    chk_out("clr_next", 1'b1, 2'b01, 2'b00, {16'h0300, 16'h0010}, 2'b00, 2'b01);
    // reset while stalled drops the pending beat and all history
    out_ready = 1'b0; in_data = {16'h0001, 16'h0001};
    tick();
    rst = 1'b1;
    tick();
    chk_out("mid_rst", 1'b0, 2'b00, 2'b00, 32'h0, 2'b00, 2'b00);
    rst = 1'b0; out_ready = 1'b1; in_data = {16'hFFFB, 16'h0007};
    tick();
    chk_out("post_rst", 1'b1, 2'b10, 2'b00, {16'h0005, 16'h0007}, 2'b00, 2'b00);
    in_valid = 1'b0;
    tick();
    chk("end_out_valid", 32'(out_valid), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
